gen_mq_sfifo: RTL and testbench
===============================

GEN_MQ_SFIFO -- requirements
Module: gen_mq_sfifo

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 36, data width in bits.
REQ-002 SHALL have parameter WIDTH_ADDR, default 6, per-channel depth of 2**WIDTH_ADDR entries.
REQ-003 SHALL have parameter NUM_CH, default 4, channel count; legal range 2..16.
REQ-004 SHALL have parameter WIDTH_CH, default 2, channel index width, equal to clog2(NUM_CH).
REQ-005 SHALL have parameter WATERAGE_UP, default 1; alfull asserts at count >= 2**WIDTH_ADDR - WATERAGE_UP.
REQ-006 SHALL have parameter WATERAGE_DOWN, default 1; alempty asserts at count <= WATERAGE_DOWN.
REQ-007 SHALL have parameter OVERLIMIT_CHECK, default 1; 1 means writes to full and reads from empty are blocked, 0 means they are unguarded.
REQ-008 SHALL have port clock, input, 1, the single clock for the whole block.
REQ-009 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-010 SHALL have port wen, input, 1, write request.
REQ-011 SHALL have port wr_ch, input, WIDTH_CH, write channel index.
REQ-012 SHALL have port wdata, input, WIDTH_DATA, write data.
REQ-013 SHALL have port ren, input, 1, read request.
REQ-014 SHALL have port rd_ch, input, WIDTH_CH, read channel index.
REQ-015 SHALL have port rdata, output, WIDTH_DATA, read data.
REQ-016 SHALL have port rvalid, output, 1, rdata valid strobe.
REQ-017 SHALL have port rvalid_ch, output, WIDTH_CH, channel of the current rdata.
REQ-018 SHALL have ports full, alfull, empty and alempty, each output, NUM_CH, per-channel status with bit i for channel i.
REQ-019 SHALL have port deep, output, NUM_CH*(WIDTH_ADDR+1), per-channel occupancy packed with channel i at [i*(WIDTH_ADDR+1) +: WIDTH_ADDR+1].

Function
REQ-020 SHALL hold all channels in one RAM of NUM_CH*2**WIDTH_ADDR words, addressed as {channel, pointer}.
REQ-021 SHALL give each channel its own WIDTH_ADDR-bit write pointer, read pointer and (WIDTH_ADDR+1)-bit count.
REQ-022 SHALL accept a write when wen=1 and (OVERLIMIT_CHECK=0 or full[wr_ch]=0): store wdata at {wr_ch, wptr}, then wptr+1 modulo 2**WIDTH_ADDR.
REQ-023 SHALL accept a read when ren=1 and (OVERLIMIT_CHECK=0 or empty[rd_ch]=0): rptr+1 modulo 2**WIDTH_ADDR.
REQ-024 SHALL drive rdata with an accepted read's data exactly 1 cycle after the read, with rvalid=1 and rvalid_ch=rd_ch; rvalid=0 otherwise.
REQ-025 SHALL hold rdata when rvalid=0.
REQ-026 SHALL change count on the same channel by +1 for a write alone, -1 for a read alone, and 0 for both in one cycle.
REQ-027 SHALL update counts on different channels independently in the same cycle.
REQ-028 SHALL give no fall-through: a read from an empty channel is rejected even with a same-cycle write to that channel.
REQ-029 SHALL reject a write to a full channel even with a same-cycle read from that channel, when OVERLIMIT_CHECK=1.
REQ-030 SHALL register full, alfull, empty, alempty and deep, reflecting counts after the clock edge, so status lags operations by 0 cycles post-edge.
REQ-031 SHALL assert full at count=2**WIDTH_ADDR and empty at count=0.
REQ-032 SHALL leave other channels unaffected by any operation on one channel.

Reset
REQ-033 SHALL on rst=1 immediately clear all pointers, counts, deep, full, alfull and rvalid, and set empty=all ones and alempty=all ones.
REQ-034 SHALL reset rdata and rvalid_ch to 0.
REQ-035 SHALL leave RAM contents uninitialised.
REQ-036 SHALL discard an in-flight read when reset arrives mid-operation; no rvalid follows reset release.
REQ-037 SHALL accept the first operation on the first rising edge after rst deasserts.

Configuration
REQ-038 SHALL provide macro GEN_MQ_SFIFO_ERR_EN.
REQ-039 SHALL, when GEN_MQ_SFIFO_ERR_EN is defined, add outputs err_ovf[NUM_CH] and err_udf[NUM_CH], set sticky on a rejected write or read for that channel and cleared only by rst.
REQ-040 SHALL, when GEN_MQ_SFIFO_ERR_EN is undefined, omit those ports and drop rejected operations silently.

Verification
REQ-041 SHALL cover, WIDTH_ADDR=2, NUM_CH=4: write 4 words to ch2 -> full[2]=1, deep ch2=4, a 5th write is dropped (err_ovf[2]=1 with the macro), and other channels stay empty.
REQ-042 SHALL cover: read ch2 four times back-to-back -> rdata is the write order, rvalid every cycle, rvalid_ch=2, then empty[2]=1.
REQ-043 SHALL cover: ch1 holding 1 word, same-cycle write ch1 and read ch1 -> deep ch1 stays 1, and old data returns next cycle.
REQ-044 SHALL cover: ch3 empty, same-cycle write and read ch3 -> read rejected, rvalid=0, deep ch3=1.
REQ-045 SHALL cover: 6 writes and reads on ch0 -> pointer wrap-around with data intact, and alfull/alempty toggle at counts 3/1.
REQ-046 SHALL cover: assert rst while a read is in flight -> rvalid=0, all empty=1, deep=0 immediately.

Source files
------------

// File: rtl/gen_mq_sfifo.sv
// gen_mq_sfifo: multi-queue synchronous FIFO. NUM_CH independent FIFOs
// share one RAM addressed as {channel, pointer}. Read data is registered
// and returned one cycle after an accepted read, tagged with its channel.
// Optional macro GEN_MQ_SFIFO_ERR_EN adds sticky per-channel overflow /
// underflow flags (err_ovf / err_udf) for rejected writes / reads.
module gen_mq_sfifo #(
    parameter int WIDTH_DATA      = 36,
    parameter int WIDTH_ADDR      = 6,
    parameter int NUM_CH          = 4,
    parameter int WIDTH_CH        = 2,
    parameter int WATERAGE_UP     = 1,
    parameter int WATERAGE_DOWN   = 1,
    parameter int OVERLIMIT_CHECK = 1
) (
    input  logic                               clock,
    input  logic                               rst,
    input  logic                               wen,
    input  logic [WIDTH_CH-1:0]                wr_ch,
    input  logic [WIDTH_DATA-1:0]              wdata,
    input  logic                               ren,
    input  logic [WIDTH_CH-1:0]                rd_ch,
    output logic [WIDTH_DATA-1:0]              rdata,
    output logic                               rvalid,
    output logic [WIDTH_CH-1:0]                rvalid_ch,
    output logic [NUM_CH-1:0]                  full,
    output logic [NUM_CH-1:0]                  alfull,
    output logic [NUM_CH-1:0]                  empty,
    output logic [NUM_CH-1:0]                  alempty,
`ifdef GEN_MQ_SFIFO_ERR_EN
    output logic [NUM_CH-1:0]                  err_ovf,
    output logic [NUM_CH-1:0]                  err_udf,
`endif
    output logic [NUM_CH*(WIDTH_ADDR+1)-1:0]   deep
);

    localparam int unsigned DEPTH = 2 ** WIDTH_ADDR;
    localparam logic [WIDTH_ADDR:0] LP_FULL = (WIDTH_ADDR+1)'(DEPTH);
    localparam logic [WIDTH_ADDR:0] LP_AF   = (WIDTH_ADDR+1)'(DEPTH - WATERAGE_UP);
    localparam logic [WIDTH_ADDR:0] LP_AE   = (WIDTH_ADDR+1)'(WATERAGE_DOWN);

    // shared storage, no reset
    logic [WIDTH_DATA-1:0]          r_mem [NUM_CH*DEPTH];

    // per-channel bookkeeping
    logic [WIDTH_ADDR-1:0]          r_wptr [NUM_CH];
    logic [WIDTH_ADDR-1:0]          r_rptr [NUM_CH];
    logic [WIDTH_ADDR:0]            r_cnt  [NUM_CH];
    logic [WIDTH_ADDR:0]            w_cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0]              r_full;
    logic [NUM_CH-1:0]              r_alfull;
    logic [NUM_CH-1:0]              r_empty;
    logic [NUM_CH-1:0]              r_alempty;

    // read return path
    logic [WIDTH_DATA-1:0]          r_rdata;
    logic                           r_rvalid;
    logic [WIDTH_CH-1:0]            r_rvalid_ch;

    // accept decisions and addresses
    logic                           w_wr_ok;
    logic                           w_rd_ok;
    logic [NUM_CH-1:0]              w_inc;
    logic [NUM_CH-1:0]              w_dec;
    logic [WIDTH_CH+WIDTH_ADDR-1:0] w_waddr;
    logic [WIDTH_CH+WIDTH_ADDR-1:0] w_raddr;

    // accept a request unless guarding is enabled and the target channel is full/empty
    always_comb begin
        w_wr_ok = wen;
        w_rd_ok = ren;
        if (OVERLIMIT_CHECK != 0) begin
            if (r_full[wr_ch]) begin
                w_wr_ok = 1'b0;
            end
            if (r_empty[rd_ch]) begin
                w_rd_ok = 1'b0;
            end
        end
        w_waddr = {wr_ch, r_wptr[wr_ch]};
        w_raddr = {rd_ch, r_rptr[rd_ch]};
    end

    // per-channel count update; a write and read on one channel cancel out
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_inc[i]     = w_wr_ok && (wr_ch == WIDTH_CH'(i));
            w_dec[i]     = w_rd_ok && (rd_ch == WIDTH_CH'(i));
            w_cnt_nxt[i] = r_cnt[i] + (WIDTH_ADDR+1)'(w_inc[i]) - (WIDTH_ADDR+1)'(w_dec[i]);
        end
    end

    // RAM write port
    always_ff @(posedge clock) begin
        if (w_wr_ok) begin
            r_mem[w_waddr] <= wdata;
        end
    end

    // pointers, counts and status flags; status is derived from the post-edge count
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_full    <= '0;
            r_alfull  <= '0;
            r_empty   <= '1;
            r_alempty <= '1;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_inc[i]) begin
                    r_wptr[i] <= r_wptr[i] + 1'b1;
                end
                if (w_dec[i]) begin
                    r_rptr[i] <= r_rptr[i] + 1'b1;
                end
                r_cnt[i]     <= w_cnt_nxt[i];
                r_full[i]    <= (w_cnt_nxt[i] == LP_FULL);
                r_alfull[i]  <= (w_cnt_nxt[i] >= LP_AF);
                r_empty[i]   <= (w_cnt_nxt[i] == '0);
                r_alempty[i] <= (w_cnt_nxt[i] <= LP_AE);
            end
        end
    end

    // registered read return; rdata holds its last value between reads
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_rvalid_ch <= '0;
        end else begin
            r_rvalid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rdata     <= r_mem[w_raddr];
                r_rvalid_ch <= rd_ch;
            end
        end
    end

`ifdef GEN_MQ_SFIFO_ERR_EN
    logic [NUM_CH-1:0] r_err_ovf;
    logic [NUM_CH-1:0] r_err_udf;

    // sticky flags for requests that were refused
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_err_ovf <= '0;
            r_err_udf <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wen && !w_wr_ok && (wr_ch == WIDTH_CH'(i))) begin
                    r_err_ovf[i] <= 1'b1;
                end
                if (ren && !w_rd_ok && (rd_ch == WIDTH_CH'(i))) begin
                    r_err_udf[i] <= 1'b1;
                end
            end
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`endif

    // pack per-channel occupancy onto the deep bus
    always_comb begin
        deep = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            deep[i*(WIDTH_ADDR+1) +: (WIDTH_ADDR+1)] = r_cnt[i];
        end
    end

    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;
    assign rvalid_ch = r_rvalid_ch;
    assign full      = r_full;
    assign alfull    = r_alfull;
    assign empty     = r_empty;
    assign alempty   = r_alempty;

endmodule

// File: tb/tb_gen_mq_sfifo.sv
// Scoreboard bench for gen_mq_sfifo: per-channel queues model the FIFOs,
// accepted reads push their expected {channel, data} into a scoreboard
// queue, and a monitor checks read returns and status every cycle.
module tb_gen_mq_sfifo;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int NCH   = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] d;
    } exp_t;

    logic                    clock;
    logic                    rst;
    logic                    wen;
    logic [CW-1:0]           wr_ch;
    logic [DW-1:0]           wdata;
    logic                    ren;
    logic [CW-1:0]           rd_ch;
    logic [DW-1:0]           rdata;
    logic                    rvalid;
    logic [CW-1:0]           rvalid_ch;
    logic [NCH-1:0]          full;
    logic [NCH-1:0]          alfull;
    logic [NCH-1:0]          empty;
    logic [NCH-1:0]          alempty;
    logic [NCH*(AW+1)-1:0]   deep;
`ifdef GEN_MQ_SFIFO_ERR_EN
    logic [NCH-1:0]          err_ovf;
    logic [NCH-1:0]          err_udf;
    logic [NCH-1:0]          m_ovf;
    logic [NCH-1:0]          m_udf;
`endif

    logic [DW-1:0] mq [NCH][$];
    exp_t          exp_q [$];
    int            total;
    int            bad;

    gen_mq_sfifo #(
        .WIDTH_DATA      (DW),
        .WIDTH_ADDR      (AW),
        .NUM_CH          (NCH),
        .WIDTH_CH        (CW),
        .WATERAGE_UP     (1),
        .WATERAGE_DOWN   (1),
        .OVERLIMIT_CHECK (1)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .wen       (wen),
        .wr_ch     (wr_ch),
        .wdata     (wdata),
        .ren       (ren),
        .rd_ch     (rd_ch),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rvalid_ch (rvalid_ch),
        .full      (full),
        .alfull    (alfull),
        .empty     (empty),
        .alempty   (alempty),
`ifdef GEN_MQ_SFIFO_ERR_EN
        .err_ovf   (err_ovf),
        .err_udf   (err_udf),
`endif
        .deep      (deep)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // drive one cycle of requests and advance the reference model
    task automatic op(input bit w, input int wc, input logic [DW-1:0] wd,
                      input bit r, input int rc);
        bit   wok;
        bit   rok;
        exp_t e;
        @(negedge clock);
        wen   = w;
        wr_ch = CW'(wc);
        wdata = wd;
        ren   = r;
        rd_ch = CW'(rc);
        wok = w && (mq[wc].size() < DEPTH);
        rok = r && (mq[rc].size() > 0);
`ifdef GEN_MQ_SFIFO_ERR_EN
        if (w && !wok) m_ovf[wc] = 1'b1;
        if (r && !rok) m_udf[rc] = 1'b1;
`endif
        if (rok) begin
            e.ch = CW'(rc);
            e.d  = mq[rc].pop_front();
            exp_q.push_back(e);
        end
        if (wok) mq[wc].push_back(wd);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) mq[i].delete();
        exp_q.delete();
`ifdef GEN_MQ_SFIFO_ERR_EN
        m_ovf = '0;
        m_udf = '0;
`endif
    endtask

    task automatic chk_reset_state();
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid_ch", rvalid_ch, 0);
        chk("rst_empty", empty, 4'hf);
        chk("rst_alempty", alempty, 4'hf);
        chk("rst_full", full, 0);
        chk("rst_alfull", alfull, 0);
        chk("rst_deep", deep, 0);
`ifdef GEN_MQ_SFIFO_ERR_EN
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_udf", err_udf, 0);
`endif
    endtask

    // monitor: read returns against the scoreboard, status against queue sizes
    initial begin : mon
        logic [DW-1:0]         last_rd;
        exp_t                  e;
        logic [NCH-1:0]        xf;
        logic [NCH-1:0]        xaf;
        logic [NCH-1:0]        xe;
        logic [NCH-1:0]        xae;
        logic [NCH*(AW+1)-1:0] xdeep;
        int                    sz;
        last_rd = '0;
        forever begin
            @(posedge clock);
            #1;
            if (rst) last_rd = '0;
            if (exp_q.size() == 0) begin
                chk("rvalid_idle", rvalid, 0);
            end else begin
                chk("rvalid_due", rvalid, 1);
                e = exp_q.pop_front();
                if (rvalid) begin
                    chk("rdata", rdata, e.d);
                    chk("rvalid_ch", rvalid_ch, e.ch);
                end
                exp_q.delete();
            end
            if (rvalid) last_rd = rdata;
            else chk("rdata_hold", rdata, last_rd);
            xdeep = '0;
            for (int i = 0; i < NCH; i++) begin
                sz = mq[i].size();
                xf[i]  = (sz == DEPTH);
                xaf[i] = (sz >= DEPTH - 1);
                xe[i]  = (sz == 0);
                xae[i] = (sz <= 1);
                xdeep[i*(AW+1) +: (AW+1)] = (AW+1)'(sz);
            end
            chk("full", full, xf);
            chk("alfull", alfull, xaf);
            chk("empty", empty, xe);
            chk("alempty", alempty, xae);
            chk("deep", deep, xdeep);
`ifdef GEN_MQ_SFIFO_ERR_EN
            chk("err_ovf", err_ovf, m_ovf);
            chk("err_udf", err_udf, m_udf);
`endif
        end
    end

    initial begin : main
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        wr_ch = '0;
        rd_ch = '0;
        wdata = '0;
        model_clear();
        #1;
        chk_reset_state();
        @(posedge clock);
        @(posedge clock);
        #2 rst = 1'b0;

        // fill ch2, then one write too many
        for (int k = 0; k < 5; k++) op(1, 2, DW'($urandom), 0, 0);
        // drain ch2 back-to-back
        for (int k = 0; k < 4; k++) op(0, 0, '0, 1, 2);
        op(0, 0, '0, 0, 0);
        // ch1 holding one word: simultaneous write and read
        op(1, 1, DW'($urandom), 0, 0);
        op(1, 1, DW'($urandom), 1, 1);
        op(0, 0, '0, 0, 0);
        // empty ch3: simultaneous write and read, read refused
        op(1, 3, DW'($urandom), 1, 3);
        op(0, 0, '0, 0, 0);
        // ch0 pointer wrap with watermark crossings
        for (int k = 0; k < 3; k++) op(1, 0, DW'($urandom), 0, 0);
        for (int k = 0; k < 2; k++) op(0, 0, '0, 1, 0);
        for (int k = 0; k < 3; k++) op(1, 0, DW'($urandom), 0, 0);
        for (int k = 0; k < 4; k++) op(0, 0, '0, 1, 0);
        op(1, 0, DW'($urandom), 0, 0);

        // reset arrives while a read request is pending on ch0
        @(negedge clock);
        wen   = 1'b0;
        ren   = 1'b1;
        rd_ch = '0;
        #3 rst = 1'b1;
        #1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_empty", empty, 4'hf);
        chk("midrst_alempty", alempty, 4'hf);
        chk("midrst_full", full, 0);
        chk("midrst_deep", deep, 0);
        model_clear();
        @(posedge clock);
        #2;
        rst = 1'b0;
        ren = 1'b0;
        // first edge after release must take this write
        op(1, 1, DW'($urandom), 0, 0);
        op(0, 0, '0, 1, 1);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            op($urandom_range(0, 99) < 60, int'($urandom_range(0, NCH-1)), DW'($urandom),
               $urandom_range(0, 99) < 55, int'($urandom_range(0, NCH-1)));
        end
        op(0, 0, '0, 0, 0);
        op(0, 0, '0, 0, 0);
        @(posedge clock);
        #3;
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
